// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the configurable UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_tx_state_t;

    localparam logic [1:0] DATA_BITS_5 = 2'd0;
    localparam logic [1:0] DATA_BITS_6 = 2'd1;
    localparam logic [1:0] DATA_BITS_7 = 2'd2;
    localparam logic [1:0] DATA_BITS_8 = 2'd3;

    // Rounded fractional baud step: round(baud * 2^acc_width / src_freq).
    function automatic longint unsigned calc_inc(input longint unsigned src_freq,
                                                 input longint unsigned baud,
                                                 input int              acc_width);
        return ((baud << acc_width) + (src_freq / 64'd2)) / src_freq;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional baud accumulator; tick fires on the cycle whose sum carries into the MSB,
// so a bit boundary cleared by the caller yields exactly ceil(2^ACC_WIDTH / INC) cycles.
module uart_baud_gen #(
    parameter int               ACC_WIDTH = 16,
    parameter logic [ACC_WIDTH:0] INC     = '0
) (
    input  logic sourceClk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    logic [ACC_WIDTH:0] acc_q;
    logic [ACC_WIDTH:0] acc_d;
    logic [ACC_WIDTH:0] sum;

    assign sum  = acc_q + INC;
    assign tick = en & sum[ACC_WIDTH];

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge sourceClk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..8 data bits, optional parity, 1 or 2 stop bits.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned SOURCE_FREQ = 25000000,
    parameter int unsigned BAUD        = 115200,
    parameter int          ACC_WIDTH   = 16
) (
    input  logic       sourceClk,
    input  logic       reset,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_byte,
    input  logic [1:0] data_bits,
    input  logic       stop2,
    input  logic       parity_en,
    input  logic       parity_odd,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_complete
);

    localparam longint unsigned INC_FULL = calc_inc(64'(SOURCE_FREQ), 64'(BAUD), ACC_WIDTH);
    localparam logic [ACC_WIDTH:0] INC = INC_FULL[ACC_WIDTH:0];

    generate
        if (INC_FULL == 64'd0 || INC_FULL >= (64'd1 << ACC_WIDTH)) begin : g_bad_inc
            $error("uart_tx_cfg: baud increment out of range for SOURCE_FREQ/BAUD/ACC_WIDTH");
        end
    endgenerate

    uart_tx_state_t state_q, state_d;
    logic [7:0]     data_q, data_d;
    logic [1:0]     nbits_q, nbits_d;
    logic           stop2_q, stop2_d;
    logic           stop_cnt_q, stop_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic           tx_out_q, tx_out_d;
    logic           ready_q, ready_d;
    logic           complete_q, complete_d;
    logic           tick;
    logic           in_idle;
    logic [2:0]     last_idx;

`ifdef UART_TX_PARITY_EN
    logic           par_en_q, par_en_d;
    logic           par_bit_q, par_bit_d;
    logic [7:0]     par_mask;
    logic           par_calc;

    // Only the configured data bits contribute to parity.
    assign par_mask = 8'hFF >> (2'd3 - data_bits);
    assign par_calc = (^(tx_byte & par_mask)) ^ parity_odd;
`else
    logic           unused_parity_inputs;
    assign unused_parity_inputs = parity_en ^ parity_odd;
`endif

    assign in_idle  = (state_q == IDLE);
    assign last_idx = 3'd4 + {1'b0, nbits_q};

    uart_baud_gen #(
        .ACC_WIDTH (ACC_WIDTH),
        .INC       (INC)
    ) u_baud (
        .sourceClk (sourceClk),
        .reset     (reset),
        .clear     (in_idle | tick),
        .en        (~in_idle),
        .tick      (tick)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        nbits_d    = nbits_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_out_d   = tx_out_q;
        ready_d    = ready_q;
        complete_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
`endif
        case (state_q)
            IDLE: begin
                ready_d  = 1'b1;
                tx_out_d = 1'b1;
                if (tx_valid && ready_q) begin
                    data_d   = tx_byte;
                    nbits_d  = data_bits;
                    stop2_d  = stop2;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = parity_en;
                    par_bit_d = par_calc;
`endif
                    tx_out_d = 1'b0;
                    ready_d  = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                    tx_out_d  = data_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == last_idx) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d  = PARITY;
                            tx_out_d = par_bit_q;
                        end else
`endif
                        begin
                            state_d    = STOP;
                            tx_out_d   = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_out_d  = data_q[bit_cnt_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d    = STOP;
                    tx_out_d   = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        complete_d = 1'b1;
                        ready_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                tx_out_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sourceClk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            nbits_q    <= DATA_BITS_8;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            bit_cnt_q  <= '0;
            tx_out_q   <= 1'b1;
            ready_q    <= 1'b0;
            complete_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            nbits_q    <= nbits_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_out_q   <= tx_out_d;
            ready_q    <= ready_d;
            complete_q <= complete_d;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    assign tx_out      = tx_out_q;
    assign tx_ready    = ready_q;
    assign tx_busy     = ~ready_q;
    assign tx_complete = complete_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg at 16 cycles per bit; expected frames come from a
// bit-list model and are checked sample-by-sample by an independent line monitor.
module tb_uart_tx_cfg;

    localparam int NCYC = 16;

    logic       sourceClk = 1'b0;
    logic       reset     = 1'b0;
    logic       tx_valid  = 1'b0;
    logic [7:0] tx_byte   = 8'h00;
    logic [1:0] data_bits = 2'd3;
    logic       stop2     = 1'b0;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       tx_ready;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_complete;

    always #5 sourceClk = ~sourceClk;

    uart_tx_cfg #(
        .SOURCE_FREQ (16),
        .BAUD        (1),
        .ACC_WIDTH   (16)
    ) dut (
        .sourceClk   (sourceClk),
        .reset       (reset),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_byte     (tx_byte),
        .data_bits   (data_bits),
        .stop2       (stop2),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .tx_out      (tx_out),
        .tx_busy     (tx_busy),
        .tx_complete (tx_complete)
    );

    typedef struct {
        logic [12:0] line;
        int          len;
        int          gap;
        bit          abort_f;
        logic [7:0]  val;
    } frame_t;

    frame_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame as a list of line levels: start, data LSb first, optional parity, stops.
    function automatic frame_t model(input logic [7:0] b, input logic [1:0] db,
                                     input logic s2, input logic pe, input logic po);
        frame_t f;
        int nd   = 5 + int'(db);
        int ones = 0;
        int k    = 0;
        f.line = '1;
        f.line[k] = 1'b0;
        k++;
        for (int i = 0; i < nd; i++) begin
            f.line[k] = b[i];
            if (b[i]) ones++;
            k++;
        end
`ifdef UART_TX_PARITY_EN
        if (pe) begin
            f.line[k] = ((ones % 2) == 1) ^ po;
            k++;
        end
`endif
        k++;
        if (s2) k++;
        f.len = k;
        f.gap = -1;
        f.abort_f = 1'b0;
        f.val = b;
        return f;
    endfunction

    task automatic send(input logic [7:0] b, input logic [1:0] db, input logic s2,
                        input logic pe, input logic po, input bit keep,
                        input bit abort_f, input int gap);
        frame_t f;
        int guard = 0;
        tx_byte = b; data_bits = db; stop2 = s2; parity_en = pe; parity_odd = po;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && guard < 1000) begin
            @(negedge sourceClk);
            guard++;
        end
        if (guard >= 1000) begin
            chk("send_ready_timeout", 32'd1, 32'd0);
        end else begin
            f = model(b, db, s2, pe, po);
            f.gap = gap;
            f.abort_f = abort_f;
            sb.push_back(f);
        end
        @(posedge sourceClk);
        #1;
        if (keep) begin
            tx_byte    = 8'($urandom);
            data_bits  = 2'($urandom);
            stop2      = 1'($urandom);
            parity_en  = 1'($urandom);
            parity_odd = 1'($urandom);
        end else begin
            tx_valid = 1'b0;
        end
    endtask

    // Line monitor: pops an expected frame on each falling start edge.
    initial begin
        frame_t e;
        int  idle_cnt = 0;
        int  fidx = 0;
        bit  aborted;
        bit  bad;
        bit  pulse_end = 1'b0;
        forever begin
            @(negedge sourceClk);
            if (!reset) begin
                idle_cnt = 0;
                pulse_end = 1'b0;
            end else if (tx_out === 1'b1) begin
                if (pulse_end) chk("complete_one_cycle", tx_complete, 1'b0);
                else if (tx_complete !== 1'b0) chk("spurious_complete", tx_complete, 1'b0);
                pulse_end = 1'b0;
                idle_cnt++;
            end else if (sb.size() == 0) begin
                chk("unexpected_frame", 32'd1, 32'd0);
            end else begin
                if (pulse_end) chk("complete_one_cycle", tx_complete, 1'b0);
                pulse_end = 1'b0;
                e = sb.pop_front();
                if (e.gap >= 0) chk($sformatf("frame%0d_idle_gap", fidx), idle_cnt, e.gap);
                aborted = 1'b0;
                bad = 1'b0;
                for (int s = 0; s < e.len * NCYC; s++) begin
                    if (s > 0) @(negedge sourceClk);
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (s % NCYC == 0) bad = 1'b0;
                    if (tx_out !== e.line[s / NCYC] || tx_complete !== 1'b0 ||
                        tx_ready !== 1'b0 || tx_busy !== 1'b1) bad = 1'b1;
                    if (s % NCYC == NCYC - 1)
                        chk($sformatf("frame%0d_bit%0d", fidx, s / NCYC), bad, 1'b0);
                end
                if (aborted) begin
                    chk($sformatf("frame%0d_abort_expected", fidx), 32'd1, e.abort_f);
                    $display("frame %0d byte=%02h aborted by reset", fidx, e.val);
                    idle_cnt = 0;
                end else begin
                    @(negedge sourceClk);
                    chk($sformatf("frame%0d_complete", fidx), tx_complete, 1'b1);
                    chk($sformatf("frame%0d_ready_end", fidx), {tx_ready, tx_busy, tx_out}, 3'b101);
                    chk($sformatf("frame%0d_not_aborted", fidx), e.abort_f, 1'b0);
                    $display("frame %0d byte=%02h bits=%0d checked", fidx, e.val, e.len);
                    idle_cnt = 1;
                    pulse_end = 1'b1;
                end
                fidx++;
            end
        end
    end

    initial begin
        int  g;
        bit  prev_keep;
        bit  keep;
        #12;
        chk("reset_tx_out", tx_out, 1'b1);
        chk("reset_tx_ready", tx_ready, 1'b0);
        chk("reset_tx_complete", tx_complete, 1'b0);
        chk("reset_tx_busy", tx_busy, 1'b1);
        @(negedge sourceClk);
        @(negedge sourceClk);
        reset = 1'b1;
        #1;
        chk("ready_before_first_edge", tx_ready, 1'b0);
        @(posedge sourceClk);
        #1;
        chk("ready_after_release", tx_ready, 1'b1);

        send(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        send(8'hFF, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        send(8'hFF, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        send(8'hA3, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        send(8'h01, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        send(8'h02, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        send(8'h81, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);

        send(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        repeat (40) @(posedge sourceClk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_tx_out", tx_out, 1'b1);
        chk("abort_tx_ready", tx_ready, 1'b0);
        chk("abort_tx_complete", tx_complete, 1'b0);
        repeat (3) begin
            @(negedge sourceClk);
            chk("no_complete_in_reset", tx_complete, 1'b0);
        end
        reset = 1'b1;
        #1;
        chk("abort_ready_before_edge", tx_ready, 1'b0);
        @(posedge sourceClk);
        #1;
        chk("abort_ready_after_release", tx_ready, 1'b1);

        prev_keep = 1'b0;
        for (int i = 0; i < 10; i++) begin
            keep = (i < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
            send(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), keep, 1'b0,
                 prev_keep ? 1 : -1);
            if (!keep) repeat ($urandom_range(0, 5)) @(negedge sourceClk);
            prev_keep = keep;
        end

        g = 0;
        while ((sb.size() != 0 || tx_ready !== 1'b1) && g < 3000) begin
            @(negedge sourceClk);
            g++;
        end
        if (g >= 3000) chk("drain_timeout", 32'd1, 32'd0);
        repeat (4) @(negedge sourceClk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
